// File: rtl/mvu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mvu_pkg
// Brief    : Shared MVU widths plus address-generator types.
// Revision : 1.0
// ============================================================================
package mvu_pkg;

  localparam int BDBANKA = 15;
  localparam int BWBANKA = 15;
  localparam int BJUMP   = 15;
  localparam int BLENGTH = 15;
  localparam int BCNTDWN = 29;
  localparam int NJUMPS  = 5;

  typedef logic [NJUMPS-1:0]       agen_z_t;
  typedef logic [NJUMPS*BJUMP-1:0] agen_jump_t;
  typedef logic [4*BLENGTH-1:0]    agen_len_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } agen_state_t;

endpackage
`default_nettype wire

// File: rtl/mvu_agen_if.sv
`default_nettype none
// ============================================================================
// Module   : mvu_agen_if
// Brief    : Config/stream bundle for one MVU address generator.
//            Optional MVU_AGEN_STALL_EN adds the stall input.
// Revision : 1.0
// ============================================================================
interface mvu_agen_if #(
  parameter int BADDR   = mvu_pkg::BDBANKA,
  parameter int BJUMP   = mvu_pkg::BJUMP,
  parameter int BLENGTH = mvu_pkg::BLENGTH,
  parameter int BCNTDWN = mvu_pkg::BCNTDWN,
  parameter int NJUMPS  = mvu_pkg::NJUMPS
);
  logic                      start;
  logic [BCNTDWN-1:0]        countdown;
  logic [BADDR-1:0]          base_addr;
  logic [NJUMPS*BJUMP-1:0]   jump;
  logic [4*BLENGTH-1:0]      length;
`ifdef MVU_AGEN_STALL_EN
  logic                      stall;
`endif
  logic                      busy;
  logic [BADDR-1:0]          addr_out;
  logic                      addr_valid;
  logic [NJUMPS-1:0]         z_out;
  logic                      done;

  modport master (
`ifdef MVU_AGEN_STALL_EN
    output stall,
`endif
    output start, countdown, base_addr, jump, length,
    input  busy, addr_out, addr_valid, z_out, done
  );

  modport slave (
`ifdef MVU_AGEN_STALL_EN
    input  stall,
`endif
    input  start, countdown, base_addr, jump, length,
    output busy, addr_out, addr_valid, z_out, done
  );
endinterface
`default_nettype wire

// File: rtl/mvu_agen_loopctr.sv
`default_nettype none
// ============================================================================
// Module   : mvu_agen_loopctr
// Brief    : One loop-level counter; keeps its own reload length.
// Revision : 1.0
// ============================================================================
module mvu_agen_loopctr #(
  parameter int BLENGTH = mvu_pkg::BLENGTH
) (
  input  wire logic               clk,
  input  wire logic               rst,
  input  wire logic               start,
  input  wire logic [BLENGTH-1:0] length,
  input  wire logic               reload,
  input  wire logic               dec,
  output logic                    zero
);
  logic [BLENGTH-1:0] r_len;
  logic [BLENGTH-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (start) begin
      r_len <= length;
      r_cnt <= length;
    end else if (reload) begin
      r_cnt <= r_len;
    end else if (dec) begin
      r_cnt <= r_cnt - BLENGTH'(1);
    end
  end

  assign zero = (r_cnt == '0);
endmodule
`default_nettype wire

// File: rtl/mvu_agen.sv
`default_nettype none
// ============================================================================
// Module   : mvu_agen
// Brief    : Nested-loop address generator for one MVU memory stream.
//            Optional MVU_AGEN_STALL_EN: stall input holds the stream in RUN.
// Revision : 1.0
// ============================================================================
module mvu_agen #(
  parameter int BADDR   = mvu_pkg::BDBANKA,
  parameter int BJUMP   = mvu_pkg::BJUMP,
  parameter int BLENGTH = mvu_pkg::BLENGTH,
  parameter int BCNTDWN = mvu_pkg::BCNTDWN,
  parameter int NJUMPS  = mvu_pkg::NJUMPS
) (
  input  wire logic  clk,
  input  wire logic  rst,
  mvu_agen_if.slave  bus
);
  import mvu_pkg::*;

  agen_state_t               r_state, w_state_nxt;
  logic [BADDR-1:0]          r_addr;
  agen_z_t                   r_z;
  logic                      r_valid;
  logic                      r_done;
  logic [BCNTDWN-1:0]        r_remain;
  logic [NJUMPS*BJUMP-1:0]   r_jump;

  logic                      w_stall;
  logic                      w_accept, w_idle_zero, w_hold, w_finish, w_adv;
  logic [3:0]                w_zero;
  logic [2:0]                w_sel;
  logic signed [BJUMP-1:0]   w_jsel;
  logic [BADDR-1:0]          w_inc;

`ifdef MVU_AGEN_STALL_EN
  assign w_stall = bus.stall;
`else
  assign w_stall = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_idle_zero = 1'b0;
    w_hold      = 1'b0;
    w_finish    = 1'b0;
    w_adv       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          if (bus.countdown != '0) begin
            w_accept    = 1'b1;
            w_state_nxt = RUN;
          end else begin
            w_idle_zero = 1'b1;
          end
        end
      end
      RUN: begin
        if (w_stall) begin
          w_hold = 1'b1;
        end else if (r_remain == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_adv = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Lowest non-exhausted level wins; all exhausted falls through to jump4.
  always_comb begin
    w_sel = 3'd4;
    for (int k = 3; k >= 0; k--) begin
      if (!w_zero[k]) w_sel = 3'(k);
    end
  end

  assign w_jsel = r_jump[w_sel*BJUMP +: BJUMP];
  assign w_inc  = BADDR'(w_jsel);

  for (genvar k = 0; k < 4; k++) begin : g_ctr
    mvu_agen_loopctr #(.BLENGTH(BLENGTH)) u_ctr (
      .clk    (clk),
      .rst    (rst),
      .start  (w_accept),
      .length (bus.length[k*BLENGTH +: BLENGTH]),
      .reload (w_adv && (w_sel > 3'(k))),
      .dec    (w_adv && (w_sel == 3'(k))),
      .zero   (w_zero[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr   <= '0;
      r_z      <= '0;
      r_valid  <= 1'b0;
      r_done   <= 1'b0;
      r_remain <= '0;
      r_jump   <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_addr   <= bus.base_addr;
        r_z      <= '0;
        r_valid  <= 1'b1;
        r_done   <= (bus.countdown == BCNTDWN'(1));
        r_remain <= bus.countdown - BCNTDWN'(1);
        r_jump   <= bus.jump;
      end else if (w_idle_zero) begin
        r_done <= 1'b1;
      end else if (w_hold) begin
        r_done <= r_done;
      end else if (w_finish) begin
        r_valid <= 1'b0;
      end else if (w_adv) begin
        r_addr   <= r_addr + w_inc;
        r_z      <= agen_z_t'(1) << w_sel;
        r_remain <= r_remain - BCNTDWN'(1);
        r_done   <= (r_remain == BCNTDWN'(1));
      end
    end
  end

  assign bus.busy       = (r_state == RUN);
  assign bus.addr_out   = r_addr;
  assign bus.addr_valid = r_valid;
  assign bus.z_out      = r_z;
  // A stalled last address is re-presented without its done pulse.
  assign bus.done       = r_done && !(w_stall && (r_state == RUN));
endmodule
`default_nettype wire

// File: tb/tb_mvu_agen.sv
`default_nettype none
// ============================================================================
// Module   : tb_mvu_agen
// Brief    : Table-driven check of mvu_agen (MVU_AGEN_STALL_EN adds stall run).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_mvu_agen;
  import mvu_pkg::*;

  typedef struct {
    logic        stall;
    logic        kick;
    logic [14:0] addr;
    agen_z_t     z;
    logic        valid;
    logic        done;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef MVU_AGEN_STALL_EN
  logic stall = 1'b0;
`endif
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mvu_agen_if bus ();
  mvu_agen dut (.clk(clk), .rst(rst), .bus(bus));

`ifdef MVU_AGEN_STALL_EN
  assign bus.stall = stall;
`endif

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input logic st, input logic kk, input int a, input int z,
                             input logic va, input logic d);
    vec_t r;
    r.stall = st; r.kick = kk; r.addr = 15'(a); r.z = agen_z_t'(z); r.valid = va; r.done = d;
    return r;
  endfunction

  task automatic set_cfg(input int base, input int cnt, input int j0, input int j1,
                         input int j4, input int l1, input int l2);
    bus.base_addr = 15'(base);
    bus.countdown = 29'(cnt);
    bus.jump      = {15'(j4), 15'd0, 15'd0, 15'(j1), 15'(j0)};
    bus.length    = {15'd0, 15'd0, 15'(l2), 15'(l1)};
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Row i is sampled at a negedge; its inputs then drive the following posedge.
  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("%s[%0d] busy/valid/done", name, i),
            {29'd0, bus.busy, bus.addr_valid, bus.done},
            {29'd0, tbl[i].valid, tbl[i].valid, tbl[i].done});
      if (tbl[i].valid)
        check($sformatf("%s[%0d] z/addr", name, i),
              {12'd0, bus.z_out, bus.addr_out}, {12'd0, tbl[i].z, tbl[i].addr});
`ifdef MVU_AGEN_STALL_EN
      stall = tbl[i].stall;
`endif
      bus.start = tbl[i].kick;
      if (tbl[i].kick) bus.base_addr = 15'd99;
      @(negedge clk);
    end
    bus.start = 1'b0;
`ifdef MVU_AGEN_STALL_EN
    stall = 1'b0;
`endif
  endtask

  task automatic load_basic();
    tbl = {};
    tbl.push_back(v(0,0,  0, 0,1,0)); tbl.push_back(v(0,0,  1, 1,1,0));
    tbl.push_back(v(0,0,  2, 1,1,0)); tbl.push_back(v(0,0, 12, 2,1,0));
    tbl.push_back(v(0,0, 13, 1,1,0)); tbl.push_back(v(0,0, 14, 1,1,0));
    tbl.push_back(v(0,0,114,16,1,0)); tbl.push_back(v(0,0,115, 1,1,1));
    tbl.push_back(v(0,0,  0, 0,0,0));
  endtask

  initial begin
    bus.start = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("reset flags", {29'd0, bus.busy, bus.addr_valid, bus.done}, 32'd0);
    check("reset z/addr", {12'd0, bus.z_out, bus.addr_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic nested sequence
    set_cfg(0, 8, 1, 10, 100, 2, 1);
    load_basic();
    pulse_start();
    run_table("basic");

    // Negative jump4 wrapping below zero
    set_cfg(2, 3, 0, 0, 15'h7FFD, 0, 0);
    tbl = {};
    tbl.push_back(v(0,0,    2, 0,1,0)); tbl.push_back(v(0,0,32767,16,1,0));
    tbl.push_back(v(0,0,32764,16,1,1)); tbl.push_back(v(0,0,    0, 0,0,0));
    pulse_start();
    run_table("wrap");

    // countdown == 0: lone done pulse, nothing emitted
    set_cfg(0, 0, 1, 10, 100, 2, 1);
    tbl = {};
    tbl.push_back(v(0,0,0,0,0,1)); tbl.push_back(v(0,0,0,0,0,0));
    tbl.push_back(v(0,0,0,0,0,0));
    pulse_start();
    run_table("cnt0");

    // Second start while busy is ignored
    set_cfg(0, 5, 1, 10, 100, 2, 1);
    tbl = {};
    tbl.push_back(v(0,0, 0,0,1,0)); tbl.push_back(v(0,1, 1,1,1,0));
    tbl.push_back(v(0,0, 2,1,1,0)); tbl.push_back(v(0,0,12,2,1,0));
    tbl.push_back(v(0,0,13,1,1,1)); tbl.push_back(v(0,0, 0,0,0,0));
    tbl.push_back(v(0,0, 0,0,0,0));
    pulse_start();
    run_table("restart");

    // Async reset between edges mid-run
    set_cfg(0, 10, 1, 10, 100, 2, 1);
    tbl = {};
    tbl.push_back(v(0,0, 0,0,1,0)); tbl.push_back(v(0,0, 1,1,1,0));
    tbl.push_back(v(0,0, 2,1,1,0)); tbl.push_back(v(0,0,12,2,1,0));
    pulse_start();
    run_table("prereset");
    #2 rst = 1'b1;
    #1;
    check("async rst flags", {29'd0, bus.busy, bus.addr_valid, bus.done}, 32'd0);
    check("async rst z/addr", {12'd0, bus.z_out, bus.addr_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post rst no done", {29'd0, bus.busy, bus.addr_valid, bus.done}, 32'd0);
    set_cfg(0, 8, 1, 10, 100, 2, 1);
    load_basic();
    pulse_start();
    run_table("after_rst");

`ifdef MVU_AGEN_STALL_EN
    // Stall holds the 2nd address three extra cycles
    set_cfg(0, 8, 1, 10, 100, 2, 1);
    tbl = {};
    tbl.push_back(v(0,0,  0, 0,1,0)); tbl.push_back(v(1,0,  1, 1,1,0));
    tbl.push_back(v(1,0,  1, 1,1,0)); tbl.push_back(v(1,0,  1, 1,1,0));
    tbl.push_back(v(0,0,  1, 1,1,0)); tbl.push_back(v(0,0,  2, 1,1,0));
    tbl.push_back(v(0,0, 12, 2,1,0)); tbl.push_back(v(0,0, 13, 1,1,0));
    tbl.push_back(v(0,0, 14, 1,1,0)); tbl.push_back(v(0,0,114,16,1,0));
    tbl.push_back(v(0,0,115, 1,1,1)); tbl.push_back(v(0,0,  0, 0,0,0));
    pulse_start();
    run_table("stall");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire
